data_mem_access_unit: RTL

- MEM-stage load/store engine, directly downstream of the EX/MEM pipeline register. Consumes its address, store data and memory-control outputs.
- Runs a multi-cycle handshake with the data memory (busywait protocol). Stalls the pipeline while an access is outstanding.
- Formats store lanes and byte enables, and sign/zero-extends load data for the MEM/WB register.

---
 rtl/data_mem_access_unit_if.sv | 34 +++
 rtl/data_mem_access_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit_if.sv
// MEM-stage bus bundle: EX/MEM request inputs, data memory handshake and MEM/WB results.
interface data_mem_access_unit_if;
  logic [31:0] MEM_ALU_OUT;
  logic [31:0] MEM_REG_DATA2;
  logic [3:0]  MEM_DATA_MEM_READ;
  logic [2:0]  MEM_DATA_MEM_WRITE;
  logic [31:0] DMEM_READDATA;
  logic        DMEM_BUSYWAIT;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WRITEDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic [31:0] LOAD_DATA;
  logic        MEM_STALL;
  logic        MISALIGNED;
  logic        BUS_ERROR;

  // The access unit drives the memory strobes and the pipeline results.
  modport master (
    input  MEM_ALU_OUT, MEM_REG_DATA2, MEM_DATA_MEM_READ, MEM_DATA_MEM_WRITE,
    input  DMEM_READDATA, DMEM_BUSYWAIT,
    output DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA, DMEM_BYTE_EN,
    output LOAD_DATA, MEM_STALL, MISALIGNED, BUS_ERROR
  );

  // Pipeline/memory side as seen from outside the unit.
  modport slave (
    output MEM_ALU_OUT, MEM_REG_DATA2, MEM_DATA_MEM_READ, MEM_DATA_MEM_WRITE,
    output DMEM_READDATA, DMEM_BUSYWAIT,
    input  DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA, DMEM_BYTE_EN,
    input  LOAD_DATA, MEM_STALL, MISALIGNED, BUS_ERROR
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store engine with busywait handshake, store lane formatting,
// load extension and access timeout.
//
// state  | meaning
// IDLE   | waiting for an aligned request from EX/MEM
// ACCESS | strobe asserted, waiting for BUSYWAIT low or timeout
// DONE   | one cycle with stall low so EX/MEM advances; never re-issues
module data_mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic CLK,
  input logic RESET,
  data_mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_store, req, size_ok, aligned, start;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic [7:0]  cnt;
  logic        timeout;
  logic        lat_store, lat_unsigned;
  logic [1:0]  lat_size, lat_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        rd_q, wr_q, err_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  be_q;

  // Decode the request: size code 00 byte, 01 half, 10 word; unsupported encodings are never aligned.
  always_comb begin
    is_store     = bus.MEM_DATA_MEM_WRITE[2];
    req          = bus.MEM_DATA_MEM_READ[3] | is_store;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    size_ok      = 1'b0;
    if (is_store) begin
      req_size = bus.MEM_DATA_MEM_WRITE[1:0];
      size_ok  = (bus.MEM_DATA_MEM_WRITE[1:0] != 2'b11);
    end else begin
      case (bus.MEM_DATA_MEM_READ[2:0])
        3'b000: size_ok = 1'b1;
        3'b001: begin req_size = 2'b01; size_ok = 1'b1; end
        3'b010: begin req_size = 2'b10; size_ok = 1'b1; end
        3'b100: begin req_unsigned = 1'b1; size_ok = 1'b1; end
        3'b101: begin req_size = 2'b01; req_unsigned = 1'b1; size_ok = 1'b1; end
        default: size_ok = 1'b0;
      endcase
    end
    case (req_size)
      2'b00:   aligned = size_ok;
      2'b01:   aligned = size_ok & ~bus.MEM_ALU_OUT[0];
      2'b10:   aligned = size_ok & (bus.MEM_ALU_OUT[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    start = req & aligned;
  end

  // Replicate store data across lanes and pick byte enables; loads enable all lanes.
  always_comb begin
    case (req_size)
      2'b00: begin
        fmt_wdata = {4{bus.MEM_REG_DATA2[7:0]}};
        fmt_be    = 4'b0001 << bus.MEM_ALU_OUT[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{bus.MEM_REG_DATA2[15:0]}};
        fmt_be    = bus.MEM_ALU_OUT[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_wdata = bus.MEM_REG_DATA2;
        fmt_be    = 4'b1111;
      end
    endcase
    if (!is_store) fmt_be = 4'b1111;
  end

  // Pull the addressed lane out of the returned word and extend it.
  always_comb begin
    ld_byte = bus.DMEM_READDATA[{lat_lane, 3'b000} +: 8];
    ld_half = bus.DMEM_READDATA[{lat_lane[1], 4'b0000} +: 16];
    case (lat_size)
      2'b00:   ld_ext = lat_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = lat_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus.DMEM_READDATA;
    endcase
  end

  assign timeout = bus.DMEM_BUSYWAIT && (cnt == 8'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (!bus.DMEM_BUSYWAIT || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational pipeline controls; DONE deliberately drops the stall.
  always_comb begin
    bus.MEM_STALL  = ((state == IDLE) && start) || (state == ACCESS);
    bus.MISALIGNED = req & ~aligned;
  end

  // Registered memory strobes, latched request attributes, load result and timeout counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      load_q       <= 32'h0;
      err_q        <= 1'b0;
      cnt          <= 8'h0;
      lat_store    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_lane     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rd_q         <= ~is_store;
            wr_q         <= is_store;
            addr_q       <= {bus.MEM_ALU_OUT[31:2], 2'b00};
            wdata_q      <= fmt_wdata;
            be_q         <= fmt_be;
            cnt          <= 8'h0;
            lat_store    <= is_store;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_lane     <= bus.MEM_ALU_OUT[1:0];
          end
        end
        ACCESS: begin
          if (!bus.DMEM_BUSYWAIT) begin
            if (!lat_store) load_q <= ld_ext;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
          end else if (timeout) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            load_q <= 32'h0;
            err_q  <= 1'b1;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        DONE:    err_q <= 1'b0;
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign bus.DMEM_READ      = rd_q;
  assign bus.DMEM_WRITE     = wr_q;
  assign bus.DMEM_ADDR      = addr_q;
  assign bus.DMEM_WRITEDATA = wdata_q;
  assign bus.DMEM_BYTE_EN   = be_q;
  assign bus.LOAD_DATA      = load_q;
  assign bus.BUS_ERROR      = err_q;

endmodule
